// File: rtl/operand_entry_pkg.sv
// Shared types and default widths for the operand entry front end of the ALU display stage.
package operand_entry_pkg;

  localparam int unsigned NBITS_OPERAND_DEFAULT          = 3;
  localparam int unsigned NBITS_OPERATION_SELECT_DEFAULT = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT        = 2;
  localparam int unsigned NBITS_COUNT_DEFAULT            = 4;
  localparam int unsigned NBITS_STATE                    = 2;

  typedef enum logic [NBITS_STATE-1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    WAIT_F = 2'd2,
    ISSUE  = 2'd3
  } entry_state_e;

endpackage

// File: rtl/switch_debouncer.sv
// Debounces a raw key level and emits a single-cycle pulse on each accepted rising edge.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stable_d;

  // Count consecutive disagreeing samples; toggle the accepted level once the run is long enough.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
      if (raw == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise_pulse = stable & ~stable_d;

endmodule

// File: rtl/operand_entry_fsm.sv
// Sequenced A/B/F entry from shared switches, handed to the ALU over a valid/ready handshake.
module operand_entry_fsm
  import operand_entry_pkg::*;
#(
  parameter int unsigned NBITS_OPERAND          = NBITS_OPERAND_DEFAULT,
  parameter int unsigned NBITS_OPERATION_SELECT = NBITS_OPERATION_SELECT_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES        = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned NBITS_COUNT            = NBITS_COUNT_DEFAULT
) (
  input  logic                              clk_2,
  input  logic                              reset,
  input  logic [NBITS_OPERAND-1:0]          sw_value,
  input  logic [NBITS_OPERATION_SELECT-1:0] sw_op,
  input  logic                              enter,
  input  logic                              out_ready,
  output logic [NBITS_OPERAND-1:0]          op_a,
  output logic [NBITS_OPERAND-1:0]          op_b,
  output logic [NBITS_OPERATION_SELECT-1:0] op_f,
  output logic                              out_valid,
  output logic [NBITS_STATE-1:0]            state_code,
  output logic [NBITS_COUNT-1:0]            issue_count
);

  entry_state_e                      state, state_nxt;
  logic                              stable_enter, rise_pulse, press, handshake;
  logic [NBITS_OPERAND-1:0]          a_sh, b_sh, a_sh_nxt, b_sh_nxt, op_a_nxt, op_b_nxt;
  logic [NBITS_OPERATION_SELECT-1:0] op_f_nxt;
  logic                              out_valid_nxt;
  logic [NBITS_COUNT-1:0]            issue_count_nxt;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_debouncer (
    .clk_2     (clk_2),
    .reset     (reset),
    .raw       (enter),
    .stable    (stable_enter),
    .rise_pulse(rise_pulse)
  );

  assign press      = rise_pulse & stable_enter;
  assign handshake  = (state == ISSUE) && out_ready;
  assign state_code = NBITS_STATE'(state);

  always_ff @(posedge clk_2) begin
    if (reset) state <= WAIT_A;
    else       state <= state_nxt;
  end

  // Presses advance entry; only the handshake leaves ISSUE, so a press there is dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_A:  if (press)     state_nxt = WAIT_B;
      WAIT_B:  if (press)     state_nxt = WAIT_F;
      WAIT_F:  if (press)     state_nxt = ISSUE;
      ISSUE:   if (handshake) state_nxt = WAIT_A;
      default:                state_nxt = WAIT_A;
    endcase
  end

  always_comb begin
    a_sh_nxt        = a_sh;
    b_sh_nxt        = b_sh;
    op_a_nxt        = op_a;
    op_b_nxt        = op_b;
    op_f_nxt        = op_f;
    out_valid_nxt   = out_valid;
    issue_count_nxt = issue_count;
    unique case (state)
      WAIT_A: if (press) a_sh_nxt = sw_value;
      WAIT_B: if (press) b_sh_nxt = sw_value;
      WAIT_F: begin
        if (press) begin
          op_a_nxt      = a_sh;
          op_b_nxt      = b_sh;
          op_f_nxt      = sw_op;
          out_valid_nxt = 1'b1;
        end
      end
      ISSUE: begin
        if (handshake) begin
          out_valid_nxt   = 1'b0;
          issue_count_nxt = issue_count + NBITS_COUNT'(1);
        end
      end
      default: ;
    endcase
  end

  // Operand outputs persist after the handshake so the last result stays on display.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      a_sh        <= '0;
      b_sh        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_f        <= '0;
      out_valid   <= 1'b0;
      issue_count <= '0;
    end else begin
      a_sh        <= a_sh_nxt;
      b_sh        <= b_sh_nxt;
      op_a        <= op_a_nxt;
      op_b        <= op_b_nxt;
      op_f        <= op_f_nxt;
      out_valid   <= out_valid_nxt;
      issue_count <= issue_count_nxt;
    end
  end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Randomized bench for operand_entry_fsm: transaction-level scoreboard plus directed boundary checks.
module tb_operand_entry_fsm;

  localparam int unsigned DEB      = 2;
  localparam int unsigned CNT_MOD  = 16;
  localparam int unsigned MAX_WAIT = 200;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sw_value = '0;
  logic [1:0] sw_op = '0;
  logic       enter = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] op_a, op_b;
  logic [1:0] op_f;
  logic       out_valid;
  logic [1:0] state_code;
  logic [3:0] issue_count;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] f;
  } txn_t;

  txn_t sb[$];
  txn_t last = '0;
  int   tests = 0;
  int   fails = 0;
  int   exp_count = 0;

  always #5 clk_2 = ~clk_2;

  operand_entry_fsm #(
    .NBITS_OPERAND(3),
    .NBITS_OPERATION_SELECT(2),
    .DEBOUNCE_CYCLES(DEB),
    .NBITS_COUNT(4)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .sw_value   (sw_value),
    .sw_op      (sw_op),
    .enter      (enter),
    .out_ready  (out_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_f       (op_f),
    .out_valid  (out_valid),
    .state_code (state_code),
    .issue_count(issue_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  // Monitor: outputs checked mid-cycle against the transaction queue and handshake count.
  always @(negedge clk_2) begin
    if (reset) begin
      sb.delete();
      exp_count = 0;
      last = '0;
    end else begin
      check("issue_count", 32'(issue_count), 32'(exp_count % CNT_MOD));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("valid_has_txn", 32'(sb.size()), 32'd1);
        end else begin
          check("sb_op_a", 32'(op_a), 32'(sb[0].a));
          check("sb_op_b", 32'(op_b), 32'(sb[0].b));
          check("sb_op_f", 32'(op_f), 32'(sb[0].f));
          if (out_ready) begin
            last = sb.pop_front();
            exp_count++;
          end
        end
      end else begin
        check("hold_op_a", 32'(op_a), 32'(last.a));
        check("hold_op_b", 32'(op_b), 32'(last.b));
        check("hold_op_f", 32'(op_f), 32'(last.f));
      end
    end
  end

  // One debounced press with the switches held steady, optionally preceded by a rejected glitch.
  task automatic press(input logic [2:0] v, input logic [1:0] f);
    sw_value = v;
    sw_op    = f;
    tick();
    if ($urandom_range(0, 1) == 1) begin
      enter = 1'b1;
      tick();
      enter = 1'b0;
      tick();
      tick();
    end
    enter = 1'b1;
    repeat (DEB + 1 + $urandom_range(0, 2)) tick();
    enter = 1'b0;
    repeat (DEB + 1 + $urandom_range(0, 2)) tick();
    sw_value = 3'($urandom);
    sw_op    = 2'($urandom);
  endtask

  task automatic entry(input logic [2:0] a, input logic [2:0] b, input logic [1:0] f);
    press(a, 2'($urandom));
    check("state_after_a", 32'(state_code), 32'd1);
    press(b, 2'($urandom));
    check("state_after_b", 32'(state_code), 32'd2);
    sb.push_back(txn_t'{a: a, b: b, f: f});
    press(3'($urandom), f);
    check("state_issue", 32'(state_code), 32'd3);
    check("valid_issue", 32'(out_valid), 32'd1);
  endtask

  task automatic complete();
    int n = 0;
    while (out_valid && n < MAX_WAIT) begin
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("handshake_done", 32'(out_valid), 32'd0);
    check("state_after_hs", 32'(state_code), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_state", 32'(state_code), 32'd0);
    check("rst_count", 32'(issue_count), 32'd0);
    reset = 1'b0;
    tick();

    // single-cycle glitch must not register
    enter = 1'b1;
    tick();
    enter = 1'b0;
    repeat (4) tick();
    check("glitch_state", 32'(state_code), 32'd0);

    // directed full entry: A=3, B=-2, F=01
    press(3'b011, 2'($urandom));
    press(3'b110, 2'($urandom));
    sb.push_back(txn_t'{a: 3'b011, b: 3'b110, f: 2'b01});
    press(3'($urandom), 2'b01);
    repeat (5) begin
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_op_a", 32'(op_a), 32'd3);
      check("full_op_b_signed", 32'($signed(op_b)), 32'hFFFF_FFFE);
      check("full_op_f", 32'(op_f), 32'd1);
      check("full_state", 32'(state_code), 32'd3);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_done_valid", 32'(out_valid), 32'd0);
    check("full_done_count", 32'(issue_count), 32'd1);
    check("full_done_state", 32'(state_code), 32'd0);
    check("full_keep_a", 32'(op_a), 32'd3);
    check("full_keep_b", 32'(op_b), 32'd6);

    // reset mid-entry
    press(3'd2, 2'($urandom));
    press(3'd1, 2'($urandom));
    check("mid_state", 32'(state_code), 32'd2);
    pulse_reset();
    check("mid_rst_a", 32'(op_a), 32'd0);
    check("mid_rst_b", 32'(op_b), 32'd0);
    check("mid_rst_f", 32'(op_f), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(issue_count), 32'd0);
    check("mid_rst_state", 32'(state_code), 32'd0);
    entry(3'd5, 3'd4, 2'd3);
    complete();

    // key held through reset release gives exactly one press
    sw_value = 3'b111;
    enter = 1'b1;
    tick();
    pulse_reset();
    repeat (6) tick();
    check("held_one_press", 32'(state_code), 32'd1);
    enter = 1'b0;
    repeat (4) tick();
    check("held_still_one", 32'(state_code), 32'd1);
    press(3'd1, 2'($urandom));
    sb.push_back(txn_t'{a: 3'b111, b: 3'd1, f: 2'd2});
    press(3'($urandom), 2'd2);
    complete();

    // press coincident with out_ready in ISSUE
    entry(3'd4, 3'd3, 2'd2);
    sw_value = 3'b101;
    enter = 1'b1;
    repeat (DEB) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("coinc_state", 32'(state_code), 32'd0);
    check("coinc_valid", 32'(out_valid), 32'd0);
    check("coinc_a_sh", 32'(dut.a_sh), 32'd4);
    enter = 1'b0;
    repeat (4) tick();
    check("coinc_no_capture", 32'(state_code), 32'd0);

    // out_ready held high throughout
    out_ready = 1'b1;
    press(3'd6, 2'($urandom));
    press(3'd2, 2'($urandom));
    sb.push_back(txn_t'{a: 3'd6, b: 3'd2, f: 2'd3});
    sw_op = 2'd3;
    tick();
    enter = 1'b1;
    repeat (DEB + 1) tick();
    check("rdyhi_valid_on", 32'(out_valid), 32'd1);
    tick();
    check("rdyhi_valid_off", 32'(out_valid), 32'd0);
    check("rdyhi_state", 32'(state_code), 32'd0);
    enter = 1'b0;
    repeat (4) tick();
    check("rdyhi_still_off", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // randomized transactions
    repeat (10) begin
      entry(3'($urandom), 3'($urandom), 2'($urandom));
      complete();
    end

    // counter wrap
    pulse_reset();
    tick();
    repeat (15) begin
      entry(3'($urandom), 3'($urandom), 2'($urandom));
      complete();
    end
    check("wrap_at_15", 32'(issue_count), 32'd15);
    entry(3'($urandom), 3'($urandom), 2'($urandom));
    complete();
    tick();
    check("wrap_to_0", 32'(issue_count), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
